// File: rtl/spi_pkg.sv
// Shared types and constants for the FPGA-side SPI master.
package spi_pkg;

    localparam int SPI_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        BYTE_DONE,
        BYTE_WAIT,
        CS_HOLD,
        CS_GAP
    } spi_state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Divide counter that times each SPI phase; reloads on load_i and flags the
// last cycle of a CLK_DIV-long phase on tick_o.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    output logic tick_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    generate
        if (CLK_DIV < 2) begin : g_bad_div
            $error("spi_tick_gen: CLK_DIV must be >= 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = load_i ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/spi_fpga_master.sv
// Byte-stream SPI master, mode 0, MSB first; cs_n is held low across a burst
// until the byte tagged tx_last has been shifted.
module spi_fpga_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_last_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       busy_o,
    output logic       sck_o,
    output logic       mosi_o,
    input  logic       miso_i,
    output logic       cs_n_o
);

    import spi_pkg::*;

    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    generate
        if (CS_GAP < 1) begin : g_bad_gap
            $error("spi_fpga_master: CS_GAP must be >= 1");
        end
    endgenerate

    spi_state_t       state_q, state_d;
    logic             accept;
    logic             div_load;
    logic             div_tick;
    logic             gap_done;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             last_q, last_d;
    logic             sck_q, sck_d;
    logic             cs_n_q, cs_n_d;
    logic             tx_ready_q, tx_ready_d;
    logic             rx_valid_q, rx_valid_d;
    logic             busy_q, busy_d;

    assign accept   = tx_valid_i && tx_ready_q;
    assign div_load = (state_d != state_q);
    assign gap_done = (gap_cnt_q == GAP_W'(CS_GAP - 1));

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (div_load),
        .tick_o  (div_tick)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The bit counter wraps 7->0 on the final SCK_LO; that wrap ends the byte.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:            if (accept)   state_d = SETUP;
            SETUP:           if (div_tick) state_d = SCK_HI;
            SCK_HI:          if (div_tick) state_d = SCK_LO;
            SCK_LO:          if (div_tick) state_d = (bit_cnt_q == 3'(SPI_BITS - 1)) ? BYTE_DONE : SCK_HI;
            BYTE_DONE:       state_d = last_q ? CS_HOLD : BYTE_WAIT;
            BYTE_WAIT:       if (accept)   state_d = SETUP;
            CS_HOLD:         if (div_tick) state_d = spi_pkg::CS_GAP;
            spi_pkg::CS_GAP: if (gap_done) state_d = IDLE;
            default:         state_d = IDLE;
        endcase
    end

    // Next values of every registered output, derived from the state being entered.
    always_comb begin
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;
        last_d     = last_q;
        gap_cnt_d  = div_load ? '0 : gap_cnt_q + 1'b1;

        if (accept) begin
            tx_shift_d = tx_data_i;
            last_d     = tx_last_i;
            bit_cnt_d  = '0;
        end
        if (state_d == SCK_HI && state_q != SCK_HI) begin
            rx_shift_d = {rx_shift_q[6:0], miso_i};
        end
        if (state_d == SCK_LO && state_q != SCK_LO) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
        if (state_q == SCK_LO && div_tick) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (state_d == BYTE_DONE) begin
            rx_data_d = rx_shift_q;
        end

        sck_d      = (state_d == SCK_HI);
        cs_n_d     = (state_d == IDLE) || (state_d == spi_pkg::CS_GAP);
        tx_ready_d = (state_d == IDLE) || (state_d == BYTE_WAIT);
        rx_valid_d = (state_d == BYTE_DONE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            last_q     <= 1'b0;
            gap_cnt_q  <= '0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            bit_cnt_q  <= bit_cnt_d;
            last_q     <= last_d;
            gap_cnt_q  <= gap_cnt_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_ready_o = tx_ready_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = busy_q;
    assign sck_o      = sck_q;
    assign mosi_o     = tx_shift_q[7];
    assign cs_n_o     = cs_n_q;

endmodule

// File: tb/tb_spi_fpga_master.sv
// Directed bench for spi_fpga_master: one CLK_DIV=4 instance (loopback or a
// behavioural mode-0 slave on miso) and one CLK_DIV=2 instance with miso stuck high.
module tb_spi_fpga_master;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid1, tx_valid2;

    logic       tx_ready1, rx_valid1, busy1, sck1, mosi1, miso1, cs_n1;
    logic [7:0] rx_data1;
    logic       tx_ready2, rx_valid2, busy2, sck2, mosi2, cs_n2;
    logic [7:0] rx_data2;

    int mode;
    localparam logic [7:0] SLAVE_BYTE = 8'hC3;
    logic [7:0] slave_shift = SLAVE_BYTE;
    logic [7:0] slave_rx    = 8'h00;

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    int cs_low1, cs_rise1, gap1, gap_ready1, sck_rise1, first_rise1;
    int cs_low2, gap2, sck_rise2, prev_rise2, bad_period2, mosi2_hi;
    logic sck1_p, cs_n1_p, sck2_p;
    logic [7:0] rx1[$];
    logic [7:0] rx2[$];

    always #5 clk = ~clk;

    spi_fpga_master #(.CLK_DIV(4), .CS_GAP(4)) dut (
        .clk_i(clk), .reset_i(reset), .tx_data_i(tx_data), .tx_last_i(tx_last),
        .tx_valid_i(tx_valid1), .tx_ready_o(tx_ready1), .rx_data_o(rx_data1),
        .rx_valid_o(rx_valid1), .busy_o(busy1), .sck_o(sck1), .mosi_o(mosi1),
        .miso_i(miso1), .cs_n_o(cs_n1)
    );

    spi_fpga_master #(.CLK_DIV(2), .CS_GAP(1)) dut2 (
        .clk_i(clk), .reset_i(reset), .tx_data_i(tx_data), .tx_last_i(tx_last),
        .tx_valid_i(tx_valid2), .tx_ready_o(tx_ready2), .rx_data_o(rx_data2),
        .rx_valid_o(rx_valid2), .busy_o(busy2), .sck_o(sck2), .mosi_o(mosi2),
        .miso_i(1'b1), .cs_n_o(cs_n2)
    );

    // Mode 0 slave model: samples mosi on sck rise, presents the next bit on sck fall.
    assign miso1 = (mode == 1) ? slave_shift[7] : mosi1;

    always @(posedge sck1) slave_rx <= {slave_rx[6:0], mosi1};

    always @(negedge sck1 or posedge cs_n1) begin
        if (cs_n1) slave_shift <= SLAVE_BYTE;
        else       slave_shift <= {slave_shift[6:0], 1'b0};
    end

    task automatic clear_mon();
        cs_low1 = 0; cs_rise1 = 0; gap1 = 0; gap_ready1 = 0; sck_rise1 = 0; first_rise1 = -1;
        cs_low2 = 0; gap2 = 0; sck_rise2 = 0; prev_rise2 = -1; bad_period2 = 0; mosi2_hi = 0;
        rx1.delete();
        rx2.delete();
        sck1_p = sck1; cs_n1_p = cs_n1; sck2_p = sck2;
    endtask

    // Advance to the next falling clock edge and record what both masters did.
    task automatic tick1();
        @(negedge clk);
        cyc++;
        if (cs_n1 === 1'b0) cs_low1++;
        if (cs_n1 === 1'b1 && cs_n1_p === 1'b0) cs_rise1++;
        if (busy1 === 1'b1 && cs_n1 === 1'b1) begin
            gap1++;
            if (tx_ready1 === 1'b1) gap_ready1++;
        end
        if (sck1 === 1'b1 && sck1_p === 1'b0) begin
            sck_rise1++;
            if (first_rise1 < 0) first_rise1 = cyc;
        end
        if (rx_valid1 === 1'b1) rx1.push_back(rx_data1);
        if (cs_n2 === 1'b0) cs_low2++;
        if (busy2 === 1'b1 && cs_n2 === 1'b1) gap2++;
        if (sck2 === 1'b1 && sck2_p === 1'b0) begin
            sck_rise2++;
            if (prev_rise2 >= 0 && cyc - prev_rise2 != 4) bad_period2++;
            prev_rise2 = cyc;
        end
        if (mosi2 !== 1'b0) mosi2_hi++;
        if (rx_valid2 === 1'b1) rx2.push_back(rx_data2);
        sck1_p = sck1; cs_n1_p = cs_n1; sck2_p = sck2;
    endtask

    task automatic send_byte(input int which, input logic [7:0] d, input logic l,
                             input logic hold, output int acc_cyc);
        int n = 0;
        tx_data = d;
        tx_last = l;
        if (which == 1) tx_valid1 = 1'b1; else tx_valid2 = 1'b1;
        while (((which == 1) ? tx_ready1 : tx_ready2) !== 1'b1 && n < 2000) begin
            tick1();
            n++;
        end
        if (n >= 2000) begin
            tests++; fails++;
            $display("[TB] FAIL send_timeout: tx_ready low for %0d cycles, want 1", n);
        end
        tick1();
        acc_cyc = cyc;
        if (!hold) begin
            tx_valid1 = 1'b0;
            tx_valid2 = 1'b0;
        end
    endtask

    task automatic wait_idle(input int which);
        int n = 0;
        while (((which == 1) ? busy1 : busy2) !== 1'b0 && n < 3000) begin
            tick1();
            n++;
        end
        if (n >= 3000) begin
            tests++; fails++;
            $display("[TB] FAIL idle_timeout: busy still high after %0d cycles, want 0", n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tx_valid1 = 1'b0; tx_valid2 = 1'b0; tx_data = 8'h00; tx_last = 1'b0; mode = 0;
        repeat (3) @(negedge clk);
        tests++; if (sck1 !== 1'b0)      begin fails++; $display("[TB] FAIL reset_sck: got %b, want 0", sck1); end
        tests++; if (mosi1 !== 1'b0)     begin fails++; $display("[TB] FAIL reset_mosi: got %b, want 0", mosi1); end
        tests++; if (cs_n1 !== 1'b1)     begin fails++; $display("[TB] FAIL reset_cs_n: got %b, want 1", cs_n1); end
        tests++; if (tx_ready1 !== 1'b0) begin fails++; $display("[TB] FAIL reset_tx_ready: got %b, want 0", tx_ready1); end
        tests++; if (rx_valid1 !== 1'b0) begin fails++; $display("[TB] FAIL reset_rx_valid: got %b, want 0", rx_valid1); end
        tests++; if (rx_data1 !== 8'h00) begin fails++; $display("[TB] FAIL reset_rx_data: got %h, want 00", rx_data1); end
        tests++; if (busy1 !== 1'b0)     begin fails++; $display("[TB] FAIL reset_busy: got %b, want 0", busy1); end
        reset = 1'b0;
        clear_mon();
        tick1();
        tests++; if (tx_ready1 !== 1'b1 || tx_ready2 !== 1'b1)
            begin fails++; $display("[TB] FAIL reset_release_ready: got %b/%b, want 1/1", tx_ready1, tx_ready2); end
    endtask

    task automatic test_loopback();
        int acc;
        logic [7:0] got;
        mode = 0;
        clear_mon();
        send_byte(1, 8'hA5, 1'b1, 1'b0, acc);
        wait_idle(1);
        got = (rx1.size() > 0) ? rx1[0] : 8'hxx;
        tests++; if (rx1.size() != 1 || got !== 8'hA5)
            begin fails++; $display("[TB] FAIL loop_rx: got %0d strobes first %h, want 1 strobe A5", rx1.size(), got); end
        tests++; if (cs_low1 != 73)    begin fails++; $display("[TB] FAIL loop_cs_low: got %0d, want 73", cs_low1); end
        tests++; if (sck_rise1 != 8)   begin fails++; $display("[TB] FAIL loop_sck_rises: got %0d, want 8", sck_rise1); end
        tests++; if (first_rise1 != acc + 4)
            begin fails++; $display("[TB] FAIL loop_first_rise: got cycle %0d, want %0d", first_rise1, acc + 4); end
        tests++; if (gap1 != 4)        begin fails++; $display("[TB] FAIL loop_cs_gap: got %0d, want 4", gap1); end
        tests++; if (gap_ready1 != 0)  begin fails++; $display("[TB] FAIL loop_gap_ready: got %0d, want 0", gap_ready1); end
        tests++; if (cs_rise1 != 1)    begin fails++; $display("[TB] FAIL loop_cs_rises: got %0d, want 1", cs_rise1); end
    endtask

    task automatic test_back_to_back();
        int acc;
        logic [7:0] g0, g1;
        mode = 0;
        clear_mon();
        send_byte(1, 8'h12, 1'b0, 1'b1, acc);
        send_byte(1, 8'h34, 1'b1, 1'b0, acc);
        wait_idle(1);
        g0 = (rx1.size() > 0) ? rx1[0] : 8'hxx;
        g1 = (rx1.size() > 1) ? rx1[1] : 8'hxx;
        tests++; if (rx1.size() != 2 || g0 !== 8'h12 || g1 !== 8'h34)
            begin fails++; $display("[TB] FAIL burst_rx: got %0d strobes %h %h, want 12 34", rx1.size(), g0, g1); end
        tests++; if (cs_rise1 != 1)   begin fails++; $display("[TB] FAIL burst_cs_rises: got %0d, want 1", cs_rise1); end
        tests++; if (cs_low1 != 143)  begin fails++; $display("[TB] FAIL burst_cs_low: got %0d, want 143", cs_low1); end
        tests++; if (gap1 != 4)       begin fails++; $display("[TB] FAIL burst_cs_gap: got %0d, want 4", gap1); end
    endtask

    task automatic test_stall();
        int acc;
        int n = 0;
        int bad = 0;
        logic [7:0] g0, g1;
        mode = 0;
        clear_mon();
        send_byte(1, 8'h5A, 1'b0, 1'b0, acc);
        while (rx1.size() == 0 && n < 500) begin
            tick1();
            n++;
        end
        tick1();
        for (int i = 0; i < 50; i++) begin
            if (cs_n1 !== 1'b0 || sck1 !== 1'b0 || tx_ready1 !== 1'b1) bad++;
            tick1();
        end
        tests++; if (bad != 0) begin fails++; $display("[TB] FAIL stall_hold: got %0d bad cycles, want 0", bad); end
        send_byte(1, 8'h3C, 1'b1, 1'b0, acc);
        wait_idle(1);
        g0 = (rx1.size() > 0) ? rx1[0] : 8'hxx;
        g1 = (rx1.size() > 1) ? rx1[1] : 8'hxx;
        tests++; if (rx1.size() != 2 || g0 !== 8'h5A || g1 !== 8'h3C)
            begin fails++; $display("[TB] FAIL stall_rx: got %0d strobes %h %h, want 5A 3C", rx1.size(), g0, g1); end
        tests++; if (sck_rise1 != 16 || cs_rise1 != 1)
            begin fails++; $display("[TB] FAIL stall_sck_cs: got %0d rises %0d cs rises, want 16 1", sck_rise1, cs_rise1); end
    endtask

    task automatic test_slave();
        int acc;
        logic [7:0] got;
        mode = 1;
        clear_mon();
        send_byte(1, 8'h41, 1'b1, 1'b0, acc);
        wait_idle(1);
        got = (rx1.size() > 0) ? rx1[0] : 8'hxx;
        tests++; if (slave_rx !== 8'h41)
            begin fails++; $display("[TB] FAIL slave_rx: got %h, want 41", slave_rx); end
        tests++; if (rx1.size() != 1 || got !== SLAVE_BYTE)
            begin fails++; $display("[TB] FAIL slave_master_rx: got %0d strobes first %h, want 1 strobe C3", rx1.size(), got); end
        mode = 0;
    endtask

    task automatic test_reset_mid();
        int acc;
        int n = 0;
        mode = 0;
        clear_mon();
        send_byte(1, 8'hFF, 1'b1, 1'b0, acc);
        while (sck_rise1 < 3 && n < 500) begin
            tick1();
            n++;
        end
        reset = 1'b1;
        tick1();
        tests++; if (cs_n1 !== 1'b1)     begin fails++; $display("[TB] FAIL midrst_cs_n: got %b, want 1", cs_n1); end
        tests++; if (sck1 !== 1'b0)      begin fails++; $display("[TB] FAIL midrst_sck: got %b, want 0", sck1); end
        tests++; if (busy1 !== 1'b0)     begin fails++; $display("[TB] FAIL midrst_busy: got %b, want 0", busy1); end
        tests++; if (tx_ready1 !== 1'b0) begin fails++; $display("[TB] FAIL midrst_tx_ready: got %b, want 0", tx_ready1); end
        reset = 1'b0;
        tick1();
        tests++; if (tx_ready1 !== 1'b1) begin fails++; $display("[TB] FAIL midrst_release_ready: got %b, want 1", tx_ready1); end
        repeat (100) tick1();
        tests++; if (rx1.size() != 0)    begin fails++; $display("[TB] FAIL midrst_rx_valid: got %0d strobes, want 0", rx1.size()); end
        tests++; if (sck_rise1 != 3 || cs_n1 !== 1'b1)
            begin fails++; $display("[TB] FAIL midrst_quiet: got %0d rises cs_n %b, want 3 1", sck_rise1, cs_n1); end
    endtask

    task automatic test_div2();
        int acc;
        logic [7:0] got;
        clear_mon();
        send_byte(2, 8'h00, 1'b1, 1'b0, acc);
        wait_idle(2);
        got = (rx2.size() > 0) ? rx2[0] : 8'hxx;
        tests++; if (rx2.size() != 1 || got !== 8'hFF)
            begin fails++; $display("[TB] FAIL div2_rx: got %0d strobes first %h, want 1 strobe FF", rx2.size(), got); end
        tests++; if (sck_rise2 != 8)   begin fails++; $display("[TB] FAIL div2_sck_rises: got %0d, want 8", sck_rise2); end
        tests++; if (bad_period2 != 0) begin fails++; $display("[TB] FAIL div2_period: got %0d bad periods, want 0", bad_period2); end
        tests++; if (mosi2_hi != 0)    begin fails++; $display("[TB] FAIL div2_mosi: got %0d high cycles, want 0", mosi2_hi); end
        tests++; if (cs_low2 != 37 || gap2 != 1)
            begin fails++; $display("[TB] FAIL div2_cs: got low %0d gap %0d, want 37 1", cs_low2, gap2); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_stall();
        test_slave();
        test_reset_mid();
        test_div2();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
